result_unloader: RTL

- Readback engine for the global buffer. After a layer completes, it streams result feature maps back to the host.
- It is the counterpart of the host loader path: the loader writes image, weight and bias data in; this block reads K_CHANNELS banks in parallel at consecutive addresses and presents each address as one beat on a valid/ready host stream.
- It owns the global-buffer read port only while busy. The top level muxes it against the core's read port.

---
 rtl/result_unloader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/result_unloader.sv
`timescale 1ns/1ps
// Global-buffer readback engine: reads K_CHANNELS banks per address and streams
// each address as one extended beat on a valid/ready host port.
module result_unloader #(
   parameter int K_CHANNELS  = 8,
   parameter int SRAM_ADDR_W = 16,
   parameter int INT_WIDTH   = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_async_n_i,
   input  logic [SRAM_ADDR_W-1:0]          cfg_base_addr_i,
   input  logic [31:0]                     cfg_len_i,
   input  logic                            cfg_sign_ext_i,
   input  logic                            start_i,
   input  logic                            abort_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [K_CHANNELS-1:0]           gb_rd_en_o,
   output logic [SRAM_ADDR_W-1:0]          gb_rd_addr_o,
   input  logic [K_CHANNELS*INT_WIDTH-1:0] gb_rd_data_i,
   output logic                            host_valid_o,
   input  logic                            host_ready_i,
   output logic [K_CHANNELS*32-1:0]        host_data_o,
   output logic [31:0]                     host_offset_o,
   output logic                            host_last_o
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DATA_W = K_CHANNELS * 32;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [SRAM_ADDR_W-1:0] base;
   logic [31:0]            len, issue_cnt, offset;
   logic                   sign_ext, inflight;
   logic [DATA_W-1:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   issue, push, pop, flush;
   logic [DATA_W-1:0]      ext_data;

   // Valid/ready: a beat moves on any edge where host_valid_o && host_ready_i;
   // the head entry is held unchanged until that happens (or abort/reset).
   assign flush = abort_i && (state != IDLE);
   // Credit: FIFO entries plus the read still in flight never exceed the depth.
   assign issue = (state == RUN) && !abort_i && (issue_cnt < len) &&
                  ((32'(count) + 32'(inflight)) < 32'(FIFO_DEPTH));
   assign push  = inflight && !flush;
   assign pop   = host_valid_o && host_ready_i;

   assign busy_o        = (state != IDLE);
   assign done_o        = (state == DONE) && !abort_i;
   assign gb_rd_en_o    = {K_CHANNELS{issue}};
   assign gb_rd_addr_o  = issue ? base + issue_cnt[SRAM_ADDR_W-1:0] : '0;
   assign host_valid_o  = (count != '0);
   assign host_data_o   = mem[rd_ptr];
   assign host_offset_o = offset;
   assign host_last_o   = host_valid_o && (offset == len - 32'd1);

   always_comb begin
      ext_data = '0;
      for (int k = 0; k < K_CHANNELS; k++) begin
         ext_data[k*32 +: 32] = {{(32-INT_WIDTH){sign_ext & gb_rd_data_i[k*INT_WIDTH + INT_WIDTH-1]}},
                                 gb_rd_data_i[k*INT_WIDTH +: INT_WIDTH]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = (cfg_len_i == 32'd0) ? DONE : RUN;
         RUN:     if (issue_cnt == len) state_nxt = DRAIN;
         DRAIN:   if (pop && host_last_o) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         base      <= '0;
         len       <= '0;
         sign_ext  <= 1'b0;
         issue_cnt <= '0;
         offset    <= '0;
         inflight  <= 1'b0;
      end else begin
         if (state == IDLE && start_i) begin
            base      <= cfg_base_addr_i;
            len       <= cfg_len_i;
            sign_ext  <= cfg_sign_ext_i;
            issue_cnt <= '0;
            offset    <= '0;
         end else begin
            if (issue) issue_cnt <= issue_cnt + 32'd1;
            if (flush)    offset <= '0;
            else if (pop) offset <= offset + 32'd1;
         end
         inflight <= issue;
      end
   end

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= ext_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule
